alu_issue_ctrl: RTL and testbench

//  Issue/sequencing front end for the combinational ALU: accepts one register-register

---
 rtl/alu_issue_pkg.sv | 42 ++++
 rtl/alu_issue_ctrl_if.sv | 23 ++
 rtl/alu_issue_ctrl_regfile.sv | 52 +++++
 rtl/alu_issue_ctrl.sv | 166 ++++++++++++++++
 tb/tb_alu_issue_ctrl.sv | 279 +++++++++++++++++++++++++++
 5 files changed

// File: rtl/alu_issue_pkg.sv
// Shared opcodes, FSM states, flag bit positions and the legal-opcode decode
// for the ALU issue controller.
package alu_issue_pkg;

  localparam int unsigned NREGS_DEF = 8;
  localparam int unsigned DW_DEF    = 32;
  localparam int unsigned OPW       = 4;
  localparam int unsigned NFLAGS    = 3;

  // Bit positions inside the {carry, overflow, equal} flag vector
  localparam int unsigned FLAG_C  = 2;
  localparam int unsigned FLAG_V  = 1;
  localparam int unsigned FLAG_EQ = 0;

  typedef logic [OPW-1:0] op_t;

  localparam op_t OP_NOP = 4'b0000;
  localparam op_t OP_ADD = 4'b0001;
  localparam op_t OP_SUB = 4'b0010;
  localparam op_t OP_AND = 4'b0101;
  localparam op_t OP_OR  = 4'b0110;
  localparam op_t OP_NOT = 4'b0111;
  localparam op_t OP_XOR = 4'b1000;
  localparam op_t OP_SHL = 4'b1001;
  localparam op_t OP_MOV = 4'b1011;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_EXEC = 2'd1,
    S_WB   = 2'd2
  } state_t;

  // True for every opcode the ALU implements (NOP included)
  function automatic logic is_legal_op(input op_t op);
    case (op)
      OP_NOP, OP_ADD, OP_SUB, OP_AND, OP_OR,
      OP_NOT, OP_XOR, OP_SHL, OP_MOV: is_legal_op = 1'b1;
      default:                        is_legal_op = 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/alu_issue_ctrl_if.sv
// Instruction handshake channel between the instruction source and the
// ALU issue controller. master = source, slave = controller.
interface alu_issue_ctrl_if #(
  parameter int unsigned AW = 3
);
  logic          instr_valid;
  logic          instr_ready;
  logic [3:0]    instr_op;
  logic          instr_muxsel;
  logic [AW-1:0] instr_rd;
  logic [AW-1:0] instr_rs1;
  logic [AW-1:0] instr_rs2;

  modport master (
    output instr_valid, instr_op, instr_muxsel, instr_rd, instr_rs1, instr_rs2,
    input  instr_ready
  );

  modport slave (
    input  instr_valid, instr_op, instr_muxsel, instr_rd, instr_rs1, instr_rs2,
    output instr_ready
  );
endinterface

// File: rtl/alu_issue_ctrl_regfile.sv
// NREGS x DW register file: one synchronous write port where writeback has
// priority over the host, and three asynchronous read ports (rs1, rs2, host).
module alu_regfile #(
  parameter int unsigned NREGS = 8,
  parameter int unsigned DW    = 32,
  localparam int unsigned AW   = $clog2(NREGS)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          wb_we,
  input  logic [AW-1:0] wb_addr,
  input  logic [DW-1:0] wb_data,
  input  logic          host_we,
  input  logic [AW-1:0] host_waddr,
  input  logic [DW-1:0] host_wdata,
  input  logic [AW-1:0] rs1_addr,
  output logic [DW-1:0] rs1_data,
  input  logic [AW-1:0] rs2_addr,
  output logic [DW-1:0] rs2_data,
  input  logic [AW-1:0] host_raddr,
  output logic [DW-1:0] host_rdata
);

  logic [DW-1:0] mem_q [NREGS];
  logic [DW-1:0] mem_d [NREGS];

  // Single write port: a writeback on the same cycle drops the host write
  always_comb begin
    mem_d = mem_q;
    if (wb_we) begin
      mem_d[wb_addr] = wb_data;
    end else if (host_we) begin
      mem_d[host_waddr] = host_wdata;
    end
  end

  // Register storage, cleared on reset
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < int'(NREGS); i++) begin
        mem_q[i] <= '0;
      end
    end else begin
      mem_q <= mem_d;
    end
  end

  assign rs1_data   = mem_q[rs1_addr];
  assign rs2_data   = mem_q[rs2_addr];
  assign host_rdata = mem_q[host_raddr];

endmodule

// File: rtl/alu_issue_ctrl.sv
// Issue/sequencing front end for the combinational ALU.
// Fixed three-cycle sequence IDLE -> EXEC -> WB; owns the register file,
// registered ALU drive, result latch and status flags.
// Build option: ALU_ISSUE_STICKY_EN makes carry/overflow sticky until reset.
module alu_issue_ctrl
  import alu_issue_pkg::*;
#(
  parameter int unsigned NREGS = NREGS_DEF,
  parameter int unsigned DW    = DW_DEF,
  localparam int unsigned AW   = $clog2(NREGS)
) (
  input  logic              clk,
  input  logic              rst_n,
  alu_issue_ctrl_if.slave   instr,
  input  logic              host_we,
  input  logic [AW-1:0]     host_waddr,
  input  logic [DW-1:0]     host_wdata,
  input  logic [AW-1:0]     host_raddr,
  output logic [DW-1:0]     host_rdata,
  output logic [OPW-1:0]    alu_opsel,
  output logic              alu_muxsel,
  output logic [DW-1:0]     alu_opa,
  output logic [DW-1:0]     alu_opb,
  input  logic [DW-1:0]     alu_result,
  input  logic              alu_carry,
  input  logic              alu_overflow,
  input  logic              alu_equal,
  output logic              done,
  output logic              illegal,
  output logic [NFLAGS-1:0] flags
);

  state_t            state_q, state_d;
  op_t               op_q, op_d;
  logic [AW-1:0]     rd_q, rd_d;
  op_t               alu_opsel_q, alu_opsel_d;
  logic              alu_muxsel_q, alu_muxsel_d;
  logic [DW-1:0]     alu_opa_q, alu_opa_d;
  logic [DW-1:0]     alu_opb_q, alu_opb_d;
  logic [DW-1:0]     res_q, res_d;
  logic [NFLAGS-1:0] rflags_q, rflags_d;
  logic [NFLAGS-1:0] flags_q, flags_d;
  logic              done_q, done_d;
  logic              illegal_q, illegal_d;
  logic              wb_we_c;
  logic [DW-1:0]     rs1_data, rs2_data;
  logic [NFLAGS-1:0] alu_flags_c;

  assign alu_flags_c = {alu_carry, alu_overflow, alu_equal};

  alu_regfile #(
    .NREGS (NREGS),
    .DW    (DW)
  ) u_rf (
    .clk        (clk),
    .rst_n      (rst_n),
    .wb_we      (wb_we_c),
    .wb_addr    (rd_q),
    .wb_data    (res_q),
    .host_we    (host_we),
    .host_waddr (host_waddr),
    .host_wdata (host_wdata),
    .rs1_addr   (instr.instr_rs1),
    .rs1_data   (rs1_data),
    .rs2_addr   (instr.instr_rs2),
    .rs2_data   (rs2_data),
    .host_raddr (host_raddr),
    .host_rdata (host_rdata)
  );

  // Next-state, operand/result capture and writeback decode
  always_comb begin
    state_d      = state_q;
    op_d         = op_q;
    rd_d         = rd_q;
    alu_opsel_d  = alu_opsel_q;
    alu_muxsel_d = alu_muxsel_q;
    alu_opa_d    = alu_opa_q;
    alu_opb_d    = alu_opb_q;
    res_d        = res_q;
    rflags_d     = rflags_q;
    flags_d      = flags_q;
    done_d       = 1'b0;
    illegal_d    = 1'b0;
    wb_we_c      = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (instr.instr_valid) begin
          state_d      = S_EXEC;
          op_d         = instr.instr_op;
          rd_d         = instr.instr_rd;
          alu_opa_d    = rs1_data;
          alu_opb_d    = rs2_data;
          alu_muxsel_d = instr.instr_muxsel;
          // Unknown opcodes present NOP to the ALU
          alu_opsel_d  = is_legal_op(instr.instr_op) ? instr.instr_op : OP_NOP;
        end
      end
      S_EXEC: begin
        state_d   = S_WB;
        res_d     = alu_result;
        rflags_d  = alu_flags_c;
        done_d    = 1'b1;
        illegal_d = !is_legal_op(op_q);
      end
      S_WB: begin
        state_d = S_IDLE;
        if (is_legal_op(op_q) && (op_q != OP_NOP)) begin
          wb_we_c = 1'b1;
`ifdef ALU_ISSUE_STICKY_EN
          flags_d[FLAG_C]  = flags_q[FLAG_C] | rflags_q[FLAG_C];
          flags_d[FLAG_V]  = flags_q[FLAG_V] | rflags_q[FLAG_V];
          flags_d[FLAG_EQ] = rflags_q[FLAG_EQ];
`else
          flags_d = rflags_q;
`endif
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // State and datapath registers; reset aborts any in-flight instruction
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= S_IDLE;
      op_q         <= OP_NOP;
      rd_q         <= '0;
      alu_opsel_q  <= OP_NOP;
      alu_muxsel_q <= 1'b0;
      alu_opa_q    <= '0;
      alu_opb_q    <= '0;
      res_q        <= '0;
      rflags_q     <= '0;
      flags_q      <= '0;
      done_q       <= 1'b0;
      illegal_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      op_q         <= op_d;
      rd_q         <= rd_d;
      alu_opsel_q  <= alu_opsel_d;
      alu_muxsel_q <= alu_muxsel_d;
      alu_opa_q    <= alu_opa_d;
      alu_opb_q    <= alu_opb_d;
      res_q        <= res_d;
      rflags_q     <= rflags_d;
      flags_q      <= flags_d;
      done_q       <= done_d;
      illegal_q    <= illegal_d;
    end
  end

  assign instr.instr_ready = (state_q == S_IDLE);
  assign alu_opsel         = alu_opsel_q;
  assign alu_muxsel        = alu_muxsel_q;
  assign alu_opa           = alu_opa_q;
  assign alu_opb           = alu_opb_q;
  assign done              = done_q;
  assign illegal           = illegal_q;
  assign flags             = flags_q;

endmodule

// File: tb/tb_alu_issue_ctrl.sv
// Directed bench for alu_issue_ctrl with a behavioural combinational ALU.
module tb_alu_issue_ctrl;
  import alu_issue_pkg::*;

  logic        clk;
  logic        rst_n;
  logic        host_we;
  logic [2:0]  host_waddr;
  logic [31:0] host_wdata;
  logic [2:0]  host_raddr;
  logic [31:0] host_rdata;
  logic [3:0]  alu_opsel;
  logic        alu_muxsel;
  logic [31:0] alu_opa, alu_opb;
  logic [31:0] alu_result;
  logic        alu_carry, alu_overflow, alu_equal;
  logic        done, illegal;
  logic [2:0]  flags;

  int n_vec;
  int n_err;
  logic [2:0] exp_flags;

  alu_issue_ctrl_if #(.AW(3)) ifc ();

  alu_issue_ctrl dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .instr        (ifc),
    .host_we      (host_we),
    .host_waddr   (host_waddr),
    .host_wdata   (host_wdata),
    .host_raddr   (host_raddr),
    .host_rdata   (host_rdata),
    .alu_opsel    (alu_opsel),
    .alu_muxsel   (alu_muxsel),
    .alu_opa      (alu_opa),
    .alu_opb      (alu_opb),
    .alu_result   (alu_result),
    .alu_carry    (alu_carry),
    .alu_overflow (alu_overflow),
    .alu_equal    (alu_equal),
    .done         (done),
    .illegal      (illegal),
    .flags        (flags)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Behavioural ALU: SUB carry is borrow, equal compares the two operands
  always_comb begin
    logic [31:0] src;
    logic [32:0] wide;
    src          = alu_muxsel ? alu_opb : alu_opa;
    wide         = '0;
    alu_result   = '0;
    alu_carry    = 1'b0;
    alu_overflow = 1'b0;
    alu_equal    = (alu_opa == alu_opb);
    case (alu_opsel)
      4'b0001: begin
        wide         = {1'b0, alu_opa} + {1'b0, alu_opb};
        alu_result   = wide[31:0];
        alu_carry    = wide[32];
        alu_overflow = (alu_opa[31] == alu_opb[31]) && (wide[31] != alu_opa[31]);
      end
      4'b0010: begin
        alu_result   = alu_opa - alu_opb;
        alu_carry    = (alu_opa < alu_opb);
        alu_overflow = (alu_opa[31] != alu_opb[31]) && (alu_result[31] != alu_opa[31]);
      end
      4'b0101: alu_result = alu_opa & alu_opb;
      4'b0110: alu_result = alu_opa | alu_opb;
      4'b0111: alu_result = ~src;
      4'b1000: alu_result = alu_opa ^ alu_opb;
      4'b1001: begin
        alu_result = {src[30:0], 1'b0};
        alu_carry  = src[31];
      end
      4'b1011: alu_result = src;
      default: alu_result = '0;
    endcase
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  function automatic logic [2:0] merge_flags(input logic [2:0] old_f, input logic [2:0] new_f);
`ifdef ALU_ISSUE_STICKY_EN
    return {old_f[2] | new_f[2], old_f[1] | new_f[1], new_f[0]};
`else
    return new_f;
`endif
  endfunction

  task automatic host_write(input logic [2:0] a, input logic [31:0] d);
    @(negedge clk);
    host_we    = 1'b1;
    host_waddr = a;
    host_wdata = d;
    @(negedge clk);
    host_we    = 1'b0;
  endtask

  task automatic check_reg(input int idx, input logic [31:0] exp);
    host_raddr = 3'(idx);
    #1;
    check($sformatf("r%0d", idx), 64'(host_rdata), 64'(exp));
  endtask

  // mode 0: plain; 1: host write 0xDEAD to rd during WB; 2: host write 100 to rs1 on accept edge
  task automatic issue(input string tag, input logic [3:0] op, input logic mux,
                       input logic [2:0] rd, input logic [2:0] rs1, input logic [2:0] rs2,
                       input int mode, input logic exp_ill, input logic wr,
                       input logic [2:0] new_flags);
    int w;
    @(negedge clk);
    ifc.instr_valid  = 1'b1;
    ifc.instr_op     = op;
    ifc.instr_muxsel = mux;
    ifc.instr_rd     = rd;
    ifc.instr_rs1    = rs1;
    ifc.instr_rs2    = rs2;
    if (mode == 2) begin
      host_we    = 1'b1;
      host_waddr = rs1;
      host_wdata = 32'd100;
    end
    w = 0;
    while (!ifc.instr_ready && w < 10) begin
      @(negedge clk);
      w++;
    end
    if (!ifc.instr_ready) begin
      check({tag, "_ready_timeout"}, 64'(ifc.instr_ready), 64'd1);
      ifc.instr_valid = 1'b0;
      host_we         = 1'b0;
      return;
    end
    @(posedge clk); #1;
    ifc.instr_valid = 1'b0;
    host_we         = 1'b0;
    check({tag, "_opsel"}, 64'(alu_opsel), 64'(exp_ill ? 4'b0000 : op));
    check({tag, "_done_exec"}, 64'(done), 64'd0);
    @(posedge clk); #1;
    check({tag, "_done_wb"}, 64'(done), 64'd1);
    check({tag, "_illegal"}, 64'(illegal), 64'(exp_ill));
    if (mode == 1) begin
      host_we    = 1'b1;
      host_waddr = rd;
      host_wdata = 32'h0000DEAD;
    end
    @(posedge clk); #1;
    host_we = 1'b0;
    check({tag, "_done_idle"}, 64'(done), 64'd0);
    check({tag, "_ready_idle"}, 64'(ifc.instr_ready), 64'd1);
    if (wr) exp_flags = merge_flags(exp_flags, new_flags);
    check({tag, "_flags"}, 64'(flags), 64'(exp_flags));
  endtask

  initial begin
    #100000;
    $display("FAIL global_timeout: got timeout expected finish");
    $fatal(1);
  end

  initial begin
    int acc_cnt, done_cnt;
    n_vec = 0;
    n_err = 0;
    exp_flags = 3'b000;
    rst_n = 1'b0;
    host_we = 1'b0; host_waddr = '0; host_wdata = '0; host_raddr = '0;
    ifc.instr_valid = 1'b0; ifc.instr_op = '0; ifc.instr_muxsel = 1'b0;
    ifc.instr_rd = '0; ifc.instr_rs1 = '0; ifc.instr_rs2 = '0;
    repeat (2) @(negedge clk);
    check("rst_ready", 64'(ifc.instr_ready), 64'd1);
    check("rst_done", 64'(done), 64'd0);
    check("rst_flags", 64'(flags), 64'd0);
    check("rst_opsel", 64'(alu_opsel), 64'd0);
    check("rst_opa", 64'(alu_opa), 64'd0);
    rst_n = 1'b1;

    // ADD with signed overflow
    host_write(3'd1, 32'h7FFFFFFF);
    host_write(3'd2, 32'h00000001);
    issue("add_ovf", OP_ADD, 1'b0, 3'd3, 3'd1, 3'd2, 0, 1'b0, 1'b1, 3'b010);
    check_reg(3, 32'h80000000);

    // SUB equal operands, then rd==rs
    host_write(3'd1, 32'd5);
    host_write(3'd2, 32'd5);
    issue("sub_eq", OP_SUB, 1'b0, 3'd1, 3'd1, 3'd2, 0, 1'b0, 1'b1, 3'b001);
    check_reg(1, 32'd0);
    issue("add_r1r1", OP_ADD, 1'b0, 3'd1, 3'd1, 3'd1, 0, 1'b0, 1'b1, 3'b001);
    check_reg(1, 32'd0);
    host_write(3'd4, 32'd3);
    issue("add_r4r4", OP_ADD, 1'b0, 3'd4, 3'd4, 3'd4, 0, 1'b0, 1'b1, 3'b001);
    check_reg(4, 32'd6);

    // SHL from rs2 with carry out
    host_write(3'd6, 32'h80000001);
    issue("shl", OP_SHL, 1'b1, 3'd5, 3'd0, 3'd6, 0, 1'b0, 1'b1, 3'b100);
    check_reg(5, 32'h00000002);

    // Illegal opcode and NOP leave state alone
    issue("illegal", 4'b0011, 1'b0, 3'd5, 3'd1, 3'd2, 0, 1'b1, 1'b0, 3'b000);
    check_reg(5, 32'h00000002);
    issue("nop", OP_NOP, 1'b0, 3'd5, 3'd4, 3'd4, 0, 1'b0, 1'b0, 3'b000);
    check_reg(5, 32'h00000002);

    // MOV from rs1
    issue("mov", OP_MOV, 1'b0, 3'd7, 3'd3, 3'd0, 0, 1'b0, 1'b1, 3'b000);
    check_reg(7, 32'h80000000);

    // Host write collides with writeback on rd
    issue("wb_collide", OP_ADD, 1'b0, 3'd2, 3'd4, 3'd4, 1, 1'b0, 1'b1, 3'b001);
    check_reg(2, 32'd12);

    // Host write to rs1 on the accept edge: operand uses old value
    issue("acc_hostwr", OP_ADD, 1'b0, 3'd6, 3'd4, 3'd4, 2, 1'b0, 1'b1, 3'b001);
    check_reg(6, 32'd12);
    check_reg(4, 32'd100);

    // Back-to-back with valid held high
    @(negedge clk);
    ifc.instr_valid = 1'b1;
    ifc.instr_op    = OP_NOP;
    acc_cnt = 0;
    done_cnt = 0;
    for (int i = 0; i < 9; i++) begin
      if (ifc.instr_ready) acc_cnt++;
      if (done) done_cnt++;
      @(negedge clk);
    end
    ifc.instr_valid = 1'b0;
    check("b2b_accepts", 64'(acc_cnt), 64'd3);
    check("b2b_dones", 64'(done_cnt), 64'd3);
    check("b2b_idle", 64'(ifc.instr_ready), 64'd1);

    // Reset during EXEC aborts the instruction
    host_write(3'd1, 32'd11);
    host_write(3'd2, 32'd22);
    @(negedge clk);
    ifc.instr_valid = 1'b1;
    ifc.instr_op    = OP_ADD;
    ifc.instr_rd    = 3'd3;
    ifc.instr_rs1   = 3'd1;
    ifc.instr_rs2   = 3'd2;
    @(posedge clk); #1;
    ifc.instr_valid = 1'b0;
    check("midexec_busy", 64'(ifc.instr_ready), 64'd0);
    rst_n = 1'b0;
    #1;
    check("midrst_ready", 64'(ifc.instr_ready), 64'd1);
    check("midrst_done", 64'(done), 64'd0);
    check("midrst_flags", 64'(flags), 64'd0);
    exp_flags = 3'b000;
    @(negedge clk);
    rst_n = 1'b1;
    done_cnt = 0;
    repeat (3) begin
      @(posedge clk); #1;
      if (done) done_cnt++;
    end
    check("midrst_nodone", 64'(done_cnt), 64'd0);
    for (int r = 0; r < 8; r++) check_reg(r, 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
